// File: rtl/uart_byte_tx_if.sv
// Byte-level handshake and serial line of the UART transmitter.
// The master drives data/valid and the slave (the transmitter) drives tx/busy.
interface uart_byte_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       tx;
    logic       busy;

    modport master (output data, output valid, input tx, input busy);
    modport slave  (input data, input valid, output tx, output busy);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte UART transmitter with a valid/busy handshake.
// tx and busy are registered; each bit lasts CLKS_PER_BIT clocks.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  bus
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          w_bit_done;

    assign w_bit_done = (r_cnt == LAST_CNT);
    assign bus.tx     = r_tx;
    assign bus.busy   = r_busy;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic; outputs are computed one edge ahead so they change with the state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = 3'd0;
                if (bus.valid) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = bus.data;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt   = ST_DATA;
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // The next bit sits in position 1 until the shift lands.
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = 3'd0;
                w_tx_nxt      = 1'b1;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: a CLKS_PER_BIT=4 instance for framing and
// handshake cases, and a default-parameter instance for the 104-cycle bit timing.
module tb_uart_byte_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    uart_byte_tx_if if4 ();
    uart_byte_tx_if if104 ();

    uart_byte_tx #(.CLKS_PER_BIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    uart_byte_tx u_dut104 (.clk(clk), .rst(rst), .bus(if104.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         pulse_busy;
        logic [9:0] exp_line;   // {stop, data[7:0], start} in the order bits leave the wire, LSB first
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one byte on the CPB=4 instance, samples each bit mid-period and checks busy timing.
    task automatic run_frame(input logic [7:0] d, input bit pulse_busy, input logic [9:0] exp_line);
        logic [9:0] got_line;
        bit         busy_ok;
        bit         idle_ok;
        got_line = 10'd0;
        busy_ok  = 1'b1;
        idle_ok  = 1'b1;
        @(negedge clk);
        check("busy_before_accept", {31'd0, if4.busy}, 32'd0);
        if4.data  = d;
        if4.valid = 1'b1;
        @(negedge clk);
        if4.valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if ((c % 4) == 2) got_line[c / 4] = if4.tx;
            if (if4.busy !== 1'b1) busy_ok = 1'b0;
            if (c == 5) if4.data = ~d;
            if (pulse_busy && (c == 13 || c == 27)) if4.valid = 1'b1;
            if (c == 14 || c == 28) if4.valid = 1'b0;
            @(negedge clk);
        end
        check("frame_bits", {22'd0, got_line}, {22'd0, exp_line});
        check("busy_high_40", {31'd0, busy_ok}, 32'd1);
        check("busy_fall_at_40", {31'd0, if4.busy}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            if (if4.busy !== 1'b0 || if4.tx !== 1'b1) idle_ok = 1'b0;
            @(negedge clk);
        end
        check("idle_after_frame", {31'd0, idle_ok}, 32'd1);
    endtask

    logic [7:0] b2b [4];
    logic [7:0] rx_byte [4];
    int         rx_start [4];

    initial begin
        bit ok;
        int t;
        int low_cnt;
        int hi_cnt;
        int busy_cnt;

        vecs[0] = '{8'h55, 1'b0, 10'b1_01010101_0};
        vecs[1] = '{8'h0D, 1'b1, 10'b1_00001101_0};
        vecs[2] = '{8'h0A, 1'b1, 10'b1_00001010_0};
        vecs[3] = '{8'h00, 1'b0, 10'b1_00000000_0};
        vecs[4] = '{8'hFF, 1'b1, 10'b1_11111111_0};
        b2b[0] = 8'h55; b2b[1] = 8'h50; b2b[2] = 8'h0D; b2b[3] = 8'h0A;

        if4.data = 8'h00;   if4.valid = 1'b0;
        if104.data = 8'h00; if104.valid = 1'b0;

        // Reset for 3 cycles, then a long idle stretch with valid low.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, if4.tx}, 32'd1);
        check("rst_busy", {31'd0, if4.busy}, 32'd0);
        rst = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if4.tx !== 1'b1 || if4.busy !== 1'b0 || if104.tx !== 1'b1 || if104.busy !== 1'b0) ok = 1'b0;
        end
        check("idle_no_valid", {31'd0, ok}, 32'd1);

        for (int i = 0; i < 5; i++) run_frame(vecs[i].data, vecs[i].pulse_busy, vecs[i].exp_line);

        // Back-to-back "UP\r\n" with an independent receiver.
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int w;
                    w = 0;
                    while (if4.busy !== 1'b0 && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 100) check("b2b_wait_idle_timeout", 32'd1, 32'd0);
                    if4.data  = b2b[i];
                    if4.valid = 1'b1;
                    @(negedge clk);
                    if4.valid = 1'b0;
                    check("b2b_busy_rise", {31'd0, if4.busy}, 32'd1);
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    int w;
                    logic [7:0] r;
                    w = 0;
                    while (if4.tx !== 1'b0 && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 200) check("rx_start_timeout", 32'd1, 32'd0);
                    rx_start[i] = cyc;
                    repeat (2) @(negedge clk);
                    check("rx_start_bit", {31'd0, if4.tx}, 32'd0);
                    for (int b = 0; b < 8; b++) begin
                        repeat (4) @(negedge clk);
                        r[b] = if4.tx;
                    end
                    repeat (4) @(negedge clk);
                    check("rx_stop_bit", {31'd0, if4.tx}, 32'd1);
                    rx_byte[i] = r;
                end
            end
        join
        for (int i = 0; i < 4; i++) check("rx_byte", {24'd0, rx_byte[i]}, {24'd0, b2b[i]});
        // 40-cycle frame plus the single IDLE cycle in which valid is accepted.
        for (int i = 0; i < 3; i++) check("b2b_spacing", rx_start[i + 1] - rx_start[i], 32'd41);
        repeat (50) @(negedge clk);

        // Reset in the middle of data bit 3 aborts the frame on the reset edge.
        if4.data  = 8'h00;
        if4.valid = 1'b1;
        @(negedge clk);
        if4.valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_tx", {31'd0, if4.tx}, 32'd0);
        check("pre_reset_busy", {31'd0, if4.busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx", {31'd0, if4.tx}, 32'd1);
        check("abort_busy", {31'd0, if4.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(8'hA3, 1'b0, 10'b1_10100011_0);

        // Default 104-cycle bit period with 0xFF.
        if104.data  = 8'hFF;
        if104.valid = 1'b1;
        @(negedge clk);
        if104.valid = 1'b0;
        low_cnt  = 0;
        hi_cnt   = 0;
        busy_cnt = 0;
        t = 0;
        while (if104.busy === 1'b1 && t < 1200) begin
            busy_cnt++;
            if (if104.tx === 1'b0) low_cnt++;
            else hi_cnt++;
            if (t == 300) if104.valid = 1'b1;
            if (t == 301) if104.valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 1200) check("def_busy_timeout", 32'd1, 32'd0);
        check("def_start_low", low_cnt, 32'd104);
        check("def_tx_high", hi_cnt, 32'd936);
        check("def_busy_len", busy_cnt, 32'd1040);
        repeat (5) @(negedge clk);
        check("def_idle_tx", {31'd0, if104.tx}, 32'd1);
        check("def_idle_busy", {31'd0, if104.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Single-byte UART transmitter, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
Accepts a byte through a valid/busy handshake and drives the serial line.
Used by the gesture debug reporter, which sends ASCII strings one byte at a time and waits for busy to rise after each request before sending the next byte.

Parameters:
CLKS_PER_BIT, default 104, clock cycles per bit period (CLK_FREQ_HZ / BAUD_RATE; 104 gives 115200 baud at 12 MHz). Legal values are 2 and above.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  reset, synchronous and active-low (0 = reset).
data  in  8  byte to transmit; sampled only on the accepting edge.
valid  in  1  transmit request; single-cycle pulse or level.
tx  out  1  serial line; idle high.
busy  out  1  high while a frame is in flight.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - tx = 1, busy = 0, state = IDLE, bit counter and cycle counter cleared.
  - Reset during a frame aborts it; tx returns high on that same edge.
- Outputs tx and busy are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx = 1, busy = 0.
  - If valid = 1 at an edge: latch data into a shift register, go to START, and on that same edge set tx = 0 and busy = 1.
  - valid = 0: remain in IDLE.
- START:
  - Hold tx = 0 for exactly CLKS_PER_BIT cycles, counted from the accepting edge.
  - Then go to DATA with bit index 0 and drive tx = data[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - Bits are sent in the order data[0] through data[7].
  - After bit 7 completes, go to STOP with tx = 1.
- STOP:
  - Hold tx = 1 for CLKS_PER_BIT cycles.
  - Then go to IDLE and set busy = 0 on that edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the accepting edge to the edge where busy falls.
- Handshake:
  - busy reads 0 in the cycle valid is presented and 1 from the next cycle on.
  - valid while busy = 1 is ignored; no queuing or buffering.
  - Changes to data during a frame have no effect on that frame.
- Back-to-back: valid high in the first cycle busy is 0 starts a new frame immediately, with no extra idle bit beyond the stop bit.
- Cycle counter runs from 0 to CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. Bit index is 3 bits.
- Any illegal state encoding returns to IDLE with tx = 1 and busy = 0.

Test Plan:
1. Reset with rst = 0 for 3 cycles, then release -> tx = 1 and busy = 0 throughout; valid = 0 keeps the line idle indefinitely.
2. CLKS_PER_BIT = 4, valid pulse with data = 0x55 ("U") -> busy high for 40 cycles.
   - Sampling tx mid-bit gives 0, 1,0,1,0,1,0,1,0, 1 (start, LSB-first data, stop).
   - busy falls exactly 40 cycles after the accepting edge.
3. Data 0x0D and 0x0A, plus valid pulses asserted while busy -> frames decode to 0x0D and 0x0A; the pulses during busy produce no additional frames.
4. Back-to-back: valid asserted in the first cycle busy is low, sending "UP\r\n" (0x55, 0x50, 0x0D, 0x0A) -> 4 contiguous frames of 10 bit periods each; a bench UART receiver decodes exactly that byte sequence.
5. Reset asserted during bit 3 of a frame -> tx = 1 and busy = 0 on the reset edge; after release, a new valid sends a complete, correct frame.
6. Default CLKS_PER_BIT = 104, data = 0xFF -> start bit low for exactly 104 cycles, then tx high for 936 cycles, busy high for 1040 cycles.
